// File: rtl/control_sequencer_if.sv
// Purpose: datapath-facing bundle for control_sequencer. The master (sequencer)
//          samples run/ir/mem_ready and drives the datapath strobes plus the
//          done/illegal/halted status; the slave side is the datapath/test side.
// Ports:   run, ir[31:0], mem_ready              -> sequencer inputs
//          PCout..HIin, Rin[15:0], Rout[15:0],
//          opcode[4:0], done, illegal, halted    -> sequencer outputs
interface control_sequencer_if;
    logic        run;
    logic [31:0] ir;
    logic        mem_ready;

    logic        PCout;
    logic        MARin;
    logic        incPC;
    logic        Zin;
    logic        PCin;
    logic        read;
    logic        MDRin;
    logic        MDRout;
    logic        IRin;
    logic        Yin;
    logic        ZLowOut;
    logic        ZHighOut;
    logic        LOin;
    logic        HIin;
    logic [15:0] Rin;
    logic [15:0] Rout;
    logic [4:0]  opcode;
    logic        done;
    logic        illegal;
    logic        halted;

    modport master (
        input  run, ir, mem_ready,
        output PCout, MARin, incPC, Zin, PCin, read, MDRin, MDRout, IRin, Yin,
               ZLowOut, ZHighOut, LOin, HIin, Rin, Rout, opcode,
               done, illegal, halted
    );

    modport slave (
        output run, ir, mem_ready,
        input  PCout, MARin, incPC, Zin, PCin, read, MDRin, MDRout, IRin, Yin,
               ZLowOut, ZHighOut, LOin, HIin, Rin, Rout, opcode,
               done, illegal, halted
    );
endinterface

// File: rtl/control_sequencer.sv
// Purpose: hardwired fetch/execute control unit. Steps T0-T2 (fetch) and
//          T3-T6 (execute) for ALU3, MUL/DIV, NOP and HALT, producing Moore
//          strobes decoded from the current state and the IR fields.
// Ports:   clock        system clock
//          clear        synchronous active-high reset
//          bus          control_sequencer_if.master (run/ir/mem_ready in,
//                       datapath strobes and status out)
//          instr_count  retired-instruction counter, wraps at 2^CNT_W
module control_sequencer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clock,
    input  logic                 clear,
    control_sequencer_if.master  bus,
    output logic [CNT_W-1:0]     instr_count
);

    typedef enum logic [3:0] {
        IDLE, T0, T1, T2, T3, T4, T5, T6, HALTED
    } state_t;

    localparam logic [4:0] OP_ALU3_MAX = 5'b01110;
    localparam logic [4:0] OP_MUL      = 5'b01111;
    localparam logic [4:0] OP_DIV      = 5'b10000;
    localparam logic [4:0] OP_NOP      = 5'b11010;
    localparam logic [4:0] OP_HALT     = 5'b11011;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    logic       is_alu3, is_muldiv, is_nop, is_halt;
    logic       retire;
    logic       unused_ir_bits;

    // IR field extraction and opcode class decode
    assign op        = bus.ir[31:27];
    assign ra        = bus.ir[26:23];
    assign rb        = bus.ir[22:19];
    assign rc        = bus.ir[18:15];
    assign is_alu3   = (op <= OP_ALU3_MAX);
    assign is_muldiv = (op == OP_MUL) || (op == OP_DIV);
    assign is_nop    = (op == OP_NOP);
    assign is_halt   = (op == OP_HALT);

    assign unused_ir_bits = ^bus.ir[14:0];
    assign instr_count    = count_q;

    // State and counter registers
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Next-state and Moore strobe decode
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        retire       = 1'b0;
        bus.PCout    = 1'b0;
        bus.MARin    = 1'b0;
        bus.incPC    = 1'b0;
        bus.Zin      = 1'b0;
        bus.PCin     = 1'b0;
        bus.read     = 1'b0;
        bus.MDRin    = 1'b0;
        bus.MDRout   = 1'b0;
        bus.IRin     = 1'b0;
        bus.Yin      = 1'b0;
        bus.ZLowOut  = 1'b0;
        bus.ZHighOut = 1'b0;
        bus.LOin     = 1'b0;
        bus.HIin     = 1'b0;
        bus.Rin      = '0;
        bus.Rout     = '0;
        bus.opcode   = '0;
        bus.done     = 1'b0;
        bus.illegal  = 1'b0;
        bus.halted   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.run) state_d = T0;
            end
            T0: begin
                bus.PCout = 1'b1;
                bus.MARin = 1'b1;
                bus.incPC = 1'b1;
                bus.Zin   = 1'b1;
                state_d   = T1;
            end
            T1: begin
                // Held until memory returns data; re-loading PC is idempotent
                bus.ZLowOut = 1'b1;
                bus.PCin    = 1'b1;
                bus.read    = 1'b1;
                bus.MDRin   = 1'b1;
                if (bus.mem_ready) state_d = T2;
            end
            T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
                state_d    = T3;
            end
            T3: begin
                if (is_alu3 || is_muldiv) begin
                    bus.Rout = 16'(16'd1 << rb);
                    bus.Yin  = 1'b1;
                    state_d  = T4;
                end else if (is_nop || is_halt) begin
                    retire = 1'b1;
                end else begin
                    bus.illegal = 1'b1;
                    state_d     = bus.run ? T0 : IDLE;
                end
            end
            T4: begin
                bus.Rout   = 16'(16'd1 << rc);
                bus.Zin    = 1'b1;
                bus.opcode = op;
                state_d    = T5;
            end
            T5: begin
                bus.ZLowOut = 1'b1;
                if (is_muldiv) begin
                    bus.LOin = 1'b1;
                    state_d  = T6;
                end else begin
                    bus.Rin = 16'(16'd1 << ra);
                    retire  = 1'b1;
                end
            end
            T6: begin
                bus.ZHighOut = 1'b1;
                bus.HIin     = 1'b1;
                retire       = 1'b1;
            end
            HALTED: begin
                bus.halted = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // Retirement is shared by every instruction class; HALT parks afterwards
        if (retire) begin
            bus.done = 1'b1;
            count_d  = count_q + CNT_W'(1);
            if (state_q == T3 && is_halt) state_d = HALTED;
            else                          state_d = bus.run ? T0 : IDLE;
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

    localparam int unsigned CNT_W = 4;

    localparam logic [16:0] S_PCOUT  = 17'h10000;
    localparam logic [16:0] S_MARIN  = 17'h08000;
    localparam logic [16:0] S_INCPC  = 17'h04000;
    localparam logic [16:0] S_ZIN    = 17'h02000;
    localparam logic [16:0] S_PCIN   = 17'h01000;
    localparam logic [16:0] S_READ   = 17'h00800;
    localparam logic [16:0] S_MDRIN  = 17'h00400;
    localparam logic [16:0] S_MDROUT = 17'h00200;
    localparam logic [16:0] S_IRIN   = 17'h00100;
    localparam logic [16:0] S_YIN    = 17'h00080;
    localparam logic [16:0] S_ZLOW   = 17'h00040;
    localparam logic [16:0] S_ZHIGH  = 17'h00020;
    localparam logic [16:0] S_LOIN   = 17'h00010;
    localparam logic [16:0] S_HIIN   = 17'h00008;
    localparam logic [16:0] S_DONE   = 17'h00004;
    localparam logic [16:0] S_ILL    = 17'h00002;
    localparam logic [16:0] S_HALT   = 17'h00001;

    typedef struct packed {
        logic [16:0]      s;
        logic [15:0]      rin;
        logic [15:0]      rout;
        logic [4:0]       opc;
        logic [CNT_W-1:0] cnt;
    } rec_t;

    logic             clock;
    logic             clear;
    logic [CNT_W-1:0] instr_count;

    control_sequencer_if bus ();

    control_sequencer #(.CNT_W(CNT_W)) dut (
        .clock       (clock),
        .clear       (clear),
        .bus         (bus),
        .instr_count (instr_count)
    );

    int               checks = 0;
    int               errors = 0;
    rec_t             exp_q[$];
    logic [CNT_W-1:0] exp_count = '0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Monitor: every cycle with visible activity must match the next expected record
    always @(negedge clock) begin : monitor
        rec_t act;
        rec_t exp;
        act.s = {bus.PCout, bus.MARin, bus.incPC, bus.Zin, bus.PCin, bus.read,
                 bus.MDRin, bus.MDRout, bus.IRin, bus.Yin, bus.ZLowOut,
                 bus.ZHighOut, bus.LOin, bus.HIin, bus.done, bus.illegal,
                 bus.halted};
        act.rin  = bus.Rin;
        act.rout = bus.Rout;
        act.opc  = bus.opcode;
        act.cnt  = instr_count;
        if ((act.s != 17'd0) || (act.rin != 16'd0) || (act.rout != 16'd0) ||
            (act.opc != 5'd0)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_cycle t=%0t act s=%h rin=%h rout=%h opc=%h cnt=%h",
                         $time, act.s, act.rin, act.rout, act.opc, act.cnt);
            end else begin
                exp = exp_q.pop_front();
                if (act !== exp) begin
                    errors++;
                    $display("FAIL cycle t=%0t act s=%h rin=%h rout=%h opc=%h cnt=%h exp s=%h rin=%h rout=%h opc=%h cnt=%h",
                             $time, act.s, act.rin, act.rout, act.opc, act.cnt,
                             exp.s, exp.rin, exp.rout, exp.opc, exp.cnt);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic push(input logic [16:0] s, input logic [15:0] rin,
                        input logic [15:0] rout, input logic [4:0] opc);
        rec_t r;
        r.s = s; r.rin = rin; r.rout = rout; r.opc = opc; r.cnt = exp_count;
        exp_q.push_back(r);
    endtask

    task automatic push_fetch(input int waits);
        push(S_PCOUT | S_MARIN | S_INCPC | S_ZIN, 16'h0, 16'h0, 5'h0);
        repeat (waits + 1) push(S_ZLOW | S_PCIN | S_READ | S_MDRIN, 16'h0, 16'h0, 5'h0);
        push(S_MDROUT | S_IRIN, 16'h0, 16'h0, 5'h0);
    endtask

    // Expected execute phase, expressed from the opcode table
    task automatic push_exec(input logic [31:0] ir);
        logic [4:0] op;
        logic [3:0] ra, rb, rc;
        op = ir[31:27]; ra = ir[26:23]; rb = ir[22:19]; rc = ir[18:15];
        if (op <= 5'd16) begin
            push(S_YIN, 16'h0, 16'(16'd1 << rb), 5'h0);
            push(S_ZIN, 16'h0, 16'(16'd1 << rc), op);
            if (op <= 5'd14) begin
                push(S_ZLOW | S_DONE, 16'(16'd1 << ra), 16'h0, 5'h0);
            end else begin
                push(S_ZLOW | S_LOIN, 16'h0, 16'h0, 5'h0);
                push(S_ZHIGH | S_HIIN | S_DONE, 16'h0, 16'h0, 5'h0);
            end
            exp_count++;
        end else if (op == 5'd26 || op == 5'd27) begin
            push(S_DONE, 16'h0, 16'h0, 5'h0);
            exp_count++;
        end else begin
            push(S_ILL, 16'h0, 16'h0, 5'h0);
        end
    endtask

    function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                         input logic [3:0] rb, input logic [3:0] rc);
        return {op, ra, rb, rc, 15'h0};
    endfunction

    // Start from IDLE: raise run for one edge, then stall T1 for 'waits' cycles.
    // Returns #1 after the last edge it consumed (a T1 cycle when waits=0).
    task automatic issue(input logic [31:0] ir, input int waits, input bit keep_run);
        bus.ir        = ir;
        bus.run       = 1'b1;
        bus.mem_ready = (waits == 0);
        @(posedge clock); #1;
        if (!keep_run) bus.run = 1'b0;
        @(posedge clock); #1;
        repeat (waits) @(posedge clock);
        #1 bus.mem_ready = 1'b1;
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clock);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("count", 32'(instr_count), 32'(exp_count));
    endtask

    initial begin
        logic [31:0] ir;
        clear         = 1'b1;
        bus.run       = 1'b0;
        bus.mem_ready = 1'b1;
        bus.ir        = 32'h0;
        repeat (2) @(posedge clock);
        #1 clear = 1'b0;

        check("reset_count", 32'(instr_count), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_strobes", 32'({bus.PCout, bus.read, bus.halted, bus.Rin, bus.Rout}), 32'd0);

        // 1: ALU op 01001, ra=4 rb=3 rc=7: Rout 0x0008 then 0x0080, Rin 0x0010
        ir = mk_ir(5'b01001, 4'd4, 4'd3, 4'd7);
        push(S_PCOUT | S_MARIN | S_INCPC | S_ZIN, 16'h0, 16'h0, 5'h0);
        push(S_ZLOW | S_PCIN | S_READ | S_MDRIN, 16'h0, 16'h0, 5'h0);
        push(S_MDROUT | S_IRIN, 16'h0, 16'h0, 5'h0);
        push(S_YIN, 16'h0, 16'h0008, 5'h0);
        push(S_ZIN, 16'h0, 16'h0080, 5'b01001);
        push(S_ZLOW | S_DONE, 16'h0010, 16'h0, 5'h0);
        exp_count = 4'd1;
        issue(ir, 0, 1'b0);
        settle(8);

        // 2: T1 stretched by three not-ready cycles; opcode 0 on rc=15
        ir = mk_ir(5'b00000, 4'd1, 4'd2, 4'd15);
        push_fetch(3);
        push_exec(ir);
        issue(ir, 3, 1'b0);
        settle(8);

        // 3: MUL and DIV use T6 and never write Rin
        ir = mk_ir(5'b01111, 4'd2, 4'd5, 4'd6);
        push_fetch(0);
        push_exec(ir);
        issue(ir, 0, 1'b0);
        settle(8);
        ir = mk_ir(5'b10000, 4'd0, 4'd15, 4'd0);
        push_fetch(0);
        push_exec(ir);
        issue(ir, 0, 1'b0);
        settle(8);

        // NOP retires at T3
        ir = mk_ir(5'b11010, 4'd9, 4'd9, 4'd9);
        push_fetch(0);
        push_exec(ir);
        issue(ir, 0, 1'b0);
        settle(6);

        // 5: illegal with run held returns to T0; next fetch runs a NOP
        ir = mk_ir(5'b11111, 4'd1, 4'd1, 4'd1);
        push_fetch(0);
        push_exec(ir);
        push_fetch(0);
        push_exec(mk_ir(5'b11010, 4'd0, 4'd0, 4'd0));
        issue(ir, 0, 1'b1);
        repeat (3) @(posedge clock);
        #1;
        bus.ir  = mk_ir(5'b11010, 4'd0, 4'd0, 4'd0);
        bus.run = 1'b0;
        settle(8);

        // Illegal with run low drops to IDLE, count unchanged
        ir = mk_ir(5'b10001, 4'd3, 4'd3, 4'd3);
        push_fetch(0);
        push_exec(ir);
        issue(ir, 0, 1'b0);
        settle(6);

        // 6: clear during T4 aborts and zeroes everything
        ir = mk_ir(5'b00011, 4'd5, 4'd6, 4'd7);
        push_fetch(0);
        push(S_YIN, 16'h0, 16'h0040, 5'h0);
        push(S_ZIN, 16'h0, 16'h0080, 5'b00011);
        issue(ir, 0, 1'b0);
        repeat (3) @(posedge clock);
        #1 clear = 1'b1;
        @(posedge clock);
        #1 clear = 1'b0;
        exp_count = '0;
        check("clear_t4_strobes", 32'({bus.Zin, bus.Yin, bus.ZLowOut, bus.opcode, bus.Rout}), 32'd0);
        settle(4);

        // Counter wraps: 17 NOPs on a 4-bit counter leaves 1
        ir = mk_ir(5'b11010, 4'd0, 4'd0, 4'd0);
        for (int i = 0; i < 17; i++) begin
            push_fetch(0);
            push_exec(ir);
            issue(ir, 0, 1'b0);
            repeat (4) @(posedge clock);
            #1;
        end
        check("wrap_count_exp", 32'(exp_count), 32'd1);
        settle(2);

        // 4: HALT retires at T3 then parks despite run=1 until clear
        ir = mk_ir(5'b11011, 4'd0, 4'd0, 4'd0);
        push_fetch(0);
        push_exec(ir);
        repeat (21) push(S_HALT, 16'h0, 16'h0, 5'h0);
        issue(ir, 0, 1'b1);
        repeat (23) @(posedge clock);
        #1;
        check("halted_level", 32'(bus.halted), 32'd1);
        clear = 1'b1;
        @(posedge clock);
        #1;
        clear   = 1'b0;
        bus.run = 1'b0;
        exp_count = '0;
        check("halt_cleared", 32'(bus.halted), 32'd0);
        settle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
